// File: rtl/fp_byte_bridge_if.sv
// Byte-link and fp_adder signal bundle for fp_byte_bridge.
// master = the bridge itself, slave = host link plus fp_adder side.
interface fp_byte_bridge_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0]  op_code;
    logic        mode_fp;
    logic        round_mode;
    logic        start;
    logic [31:0] result;
    logic [4:0]  flags;
    logic        valid_out;

    modport master (
        input  in_data, in_valid, out_ready, result, flags, valid_out,
        output in_ready, out_data, out_valid, op_a, op_b, op_code,
               mode_fp, round_mode, start
    );

    modport slave (
        output in_data, in_valid, out_ready, result, flags, valid_out,
        input  in_ready, out_data, out_valid, op_a, op_b, op_code,
               mode_fp, round_mode, start
    );
endinterface

// File: rtl/fp_byte_bridge.sv
// Byte-stream front end for fp_adder: assembles a 9-byte command frame,
// pulses start, then returns a 5-byte result/flags/timeout response.
module fp_byte_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fp_byte_bridge_if.master  bus
);

    typedef enum logic [1:0] {
        S_RX    = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_TX    = 2'd3
    } state_t;

    state_t             state_q;
    logic [3:0]         idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        op_a_q;
    logic [31:0]        op_b_q;
    logic [2:0]         op_code_q;
    logic               mode_fp_q;
    logic               round_mode_q;
    logic               start_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [7:0]         out_data_q;
    logic [31:0]        res_q;
    logic [4:0]         flags_q;
    logic               tmo_q;

    // Response byte k: result little-endian, then {timeout, 2'b00, flags}.
    function automatic logic [7:0] resp_byte(input logic [31:0] res,
                                             input logic [4:0]  flg,
                                             input logic        tmo,
                                             input logic [3:0]  idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = res[7:0];
            4'd1:    b = res[15:8];
            4'd2:    b = res[23:16];
            4'd3:    b = res[31:24];
            4'd4:    b = {tmo, 2'b00, flg};
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Frame assembly, issue, result wait/timeout and response streaming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RX;
            idx_q        <= 4'd0;
            cnt_q        <= {CNT_W{1'b0}};
            op_a_q       <= 32'h0000_0000;
            op_b_q       <= 32'h0000_0000;
            op_code_q    <= 3'd0;
            mode_fp_q    <= 1'b0;
            round_mode_q <= 1'b0;
            start_q      <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            res_q        <= 32'h0000_0000;
            flags_q      <= 5'd0;
            tmo_q        <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_RX: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    if (in_ready_q && bus.in_valid) begin
                        case (idx_q)
                            4'd0: op_a_q[7:0]   <= bus.in_data;
                            4'd1: op_a_q[15:8]  <= bus.in_data;
                            4'd2: op_a_q[23:16] <= bus.in_data;
                            4'd3: op_a_q[31:24] <= bus.in_data;
                            4'd4: op_b_q[7:0]   <= bus.in_data;
                            4'd5: op_b_q[15:8]  <= bus.in_data;
                            4'd6: op_b_q[23:16] <= bus.in_data;
                            4'd7: op_b_q[31:24] <= bus.in_data;
                            4'd8: begin
                                op_code_q    <= bus.in_data[2:0];
                                mode_fp_q    <= bus.in_data[3];
                                round_mode_q <= bus.in_data[4];
                            end
                            default: op_a_q <= op_a_q;
                        endcase
                        if (idx_q == 4'd8) begin
                            idx_q      <= 4'd0;
                            state_q    <= S_ISSUE;
                            start_q    <= 1'b1;
                            in_ready_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end else begin
                        idx_q <= idx_q;
                    end
                end
                S_ISSUE: begin
                    cnt_q <= {CNT_W{1'b0}};
                    if (bus.valid_out) begin
                        res_q       <= bus.result;
                        flags_q     <= bus.flags;
                        tmo_q       <= 1'b0;
                        out_data_q  <= bus.result[7:0];
                        out_valid_q <= 1'b1;
                        state_q     <= S_TX;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    // A result arriving on the timeout cycle takes priority.
                    if (bus.valid_out) begin
                        res_q       <= bus.result;
                        flags_q     <= bus.flags;
                        tmo_q       <= 1'b0;
                        out_data_q  <= bus.result[7:0];
                        out_valid_q <= 1'b1;
                        state_q     <= S_TX;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        res_q       <= 32'hFFFF_FFFF;
                        flags_q     <= 5'd0;
                        tmo_q       <= 1'b1;
                        out_data_q  <= 8'hFF;
                        out_valid_q <= 1'b1;
                        state_q     <= S_TX;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_TX: begin
                    if (out_valid_q && bus.out_ready) begin
                        if (idx_q == 4'd4) begin
                            idx_q       <= 4'd0;
                            out_valid_q <= 1'b0;
                            out_data_q  <= 8'h00;
                            in_ready_q  <= 1'b1;
                            state_q     <= S_RX;
                        end else begin
                            idx_q      <= idx_q + 4'd1;
                            out_data_q <= resp_byte(res_q, flags_q, tmo_q, idx_q + 4'd1);
                        end
                    end else begin
                        out_data_q <= out_data_q;
                    end
                end
                default: begin
                    state_q     <= S_RX;
                    idx_q       <= 4'd0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.op_a       = op_a_q;
    assign bus.op_b       = op_b_q;
    assign bus.op_code    = op_code_q;
    assign bus.mode_fp    = mode_fp_q;
    assign bus.round_mode = round_mode_q;
    assign bus.start      = start_q;

endmodule

// File: tb/tb_fp_byte_bridge.sv
// Directed bench for fp_byte_bridge: frames in, stubbed fp_adder, responses out.
module tb_fp_byte_bridge;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    bit   start_seen  = 1'b0;

    localparam logic [71:0] FRAME_BASIC =
        {8'h08, 8'h40, 8'h00, 8'h00, 8'h00, 8'h3F, 8'h80, 8'h00, 8'h00};

    fp_byte_bridge_if bus ();

    fp_byte_bridge #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [71:0] f, input int maxgap);
        int gap;
        int n;
        start_seen = 1'b0;
        for (int k = 0; k < 9; k++) begin
            gap = (maxgap == 0) ? 0 : $urandom_range(0, maxgap);
            bus.in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                if (bus.start === 1'b1) start_seen = 1'b1;
                tick();
            end
            bus.in_data  = f[8*k +: 8];
            bus.in_valid = 1'b1;
            n = 0;
            while (bus.in_ready !== 1'b1 && n < 50) begin
                if (bus.start === 1'b1) start_seen = 1'b1;
                tick();
                n++;
            end
            check($sformatf("in_ready_wait%0d", k), {31'd0, bus.in_ready}, 32'd1);
            if (bus.start === 1'b1) start_seen = 1'b1;
            tick();
            bus.in_valid = 1'b0;
        end
        check("start_early", {31'd0, start_seen}, 32'd0);
    endtask

    task automatic check_issue(input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] code, input logic fp, input logic rm);
        check("start_pulse", {31'd0, bus.start}, 32'd1);
        check("op_a", bus.op_a, a);
        check("op_b", bus.op_b, b);
        check("op_code", {29'd0, bus.op_code}, {29'd0, code});
        check("mode_fp", {31'd0, bus.mode_fp}, {31'd0, fp});
        check("round_mode", {31'd0, bus.round_mode}, {31'd0, rm});
    endtask

    task automatic stub(input int delay, input logic [31:0] res, input logic [4:0] flg);
        for (int d = 0; d < delay; d++) begin
            tick();
            if (d == 0) check("start_width", {31'd0, bus.start}, 32'd0);
        end
        bus.result    = res;
        bus.flags     = flg;
        bus.valid_out = 1'b1;
        tick();
        bus.valid_out = 1'b0;
        bus.result    = 32'h0;
        bus.flags     = 5'd0;
        check("start_after", {31'd0, bus.start}, 32'd0);
    endtask

    task automatic recv(input logic [39:0] exp, input int stall_at, input int stall_len);
        int n;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (bus.out_valid !== 1'b1 && n < 50) begin
                tick();
                n++;
            end
            check($sformatf("out_valid%0d", k), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("resp_byte%0d", k), {24'd0, bus.out_data}, {24'd0, exp[8*k +: 8]});
            if (k == stall_at) begin
                bus.out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
                    check("stall_data", {24'd0, bus.out_data}, {24'd0, exp[8*k +: 8]});
                end
                bus.out_ready = 1'b1;
            end
            tick();
        end
        check("out_valid_drop", {31'd0, bus.out_valid}, 32'd0);
        tick();
        check("no_extra_byte", {31'd0, bus.out_valid}, 32'd0);
        check("in_ready_back", {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.result    = 32'h0;
        bus.flags     = 5'd0;
        bus.valid_out = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_start", {31'd0, bus.start}, 32'd0);
        check("rst_op_a", bus.op_a, 32'h0);
        check("rst_out_data", {24'd0, bus.out_data}, 32'h0);
        rst_n = 1'b1;
        tick();
        check("in_ready_rise", {31'd0, bus.in_ready}, 32'd1);

        // Basic operation.
        send_frame(FRAME_BASIC, 0);
        check_issue(32'h3F80_0000, 32'h4000_0000, 3'd0, 1'b1, 1'b0);
        stub(3, 32'h4040_0000, 5'h00);
        recv({8'h00, 8'h40, 8'h40, 8'h00, 8'h00}, -1, 0);

        // Spurious valid_out in RX, gapped input, output backpressure.
        bus.result    = 32'hDEAD_BEEF;
        bus.flags     = 5'h1F;
        bus.valid_out = 1'b1;
        tick();
        bus.valid_out = 1'b0;
        check("spurious_ignored", {31'd0, bus.out_valid}, 32'd0);
        send_frame(FRAME_BASIC, 5);
        check_issue(32'h3F80_0000, 32'h4000_0000, 3'd0, 1'b1, 1'b0);
        stub(3, 32'h4040_0000, 5'h05);
        recv({8'h05, 8'h40, 8'h40, 8'h00, 8'h00}, 2, 7);

        // Timeout: no result ever arrives.
        send_frame({8'hF5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88}, 0);
        check_issue(32'h5566_7788, 32'h1122_3344, 3'd5, 1'b0, 1'b1);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check("timeout_latency", lat, 32'd9);
        recv({8'h80, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, -1, 0);

        // Result on the last WAIT cycle beats the timeout.
        send_frame(FRAME_BASIC, 0);
        check_issue(32'h3F80_0000, 32'h4000_0000, 3'd0, 1'b1, 1'b0);
        stub(8, 32'h1234_5678, 5'h10);
        recv({8'h10, 8'h12, 8'h34, 8'h56, 8'h78}, -1, 0);

        // Result during the issue cycle skips WAIT.
        send_frame(FRAME_BASIC, 0);
        check_issue(32'h3F80_0000, 32'h4000_0000, 3'd0, 1'b1, 1'b0);
        stub(0, 32'hC000_0000, 5'h01);
        check("issue_result_tx", {31'd0, bus.out_valid}, 32'd1);
        recv({8'h01, 8'hC0, 8'h00, 8'h00, 8'h00}, -1, 0);

        // Reset after six bytes discards the partial frame.
        for (int k = 0; k < 6; k++) begin
            bus.in_data  = FRAME_BASIC[8*k +: 8];
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("mid_rst_op_a", bus.op_a, 32'h0);
        check("mid_rst_op_b", bus.op_b, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("mid_rst_no_start", {31'd0, bus.start}, 32'd0);
        end
        send_frame(FRAME_BASIC, 0);
        check_issue(32'h3F80_0000, 32'h4000_0000, 3'd0, 1'b1, 1'b0);
        stub(3, 32'h4040_0000, 5'h00);
        recv({8'h00, 8'h40, 8'h40, 8'h00, 8'h00}, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
